// File: rtl/aes_key_expand_ctrl_pkg.sv
// aes_key_expand_ctrl_pkg
// Shared AES-128 key-expansion constants and types: round count, round-key
// slot count, rcon seed and reduction polynomial, controller FSM encoding,
// the 128-bit round-key type and the rcon doubling helper.
// No ports (package).

package aes_key_expand_ctrl_pkg;

    localparam int unsigned AES_NR        = 10;
    localparam int unsigned AES_RK_NUM    = 11;
    localparam logic [7:0]  AES_RCON_INIT = 8'h01;
    localparam logic [7:0]  AES_RCON_POLY = 8'h1b;

    typedef enum logic [1:0] {
        StIdle,
        StExpand,
        StReady
    } aes_kexp_state_e;

    typedef logic [127:0] aes_rk_t;

    // xtime in GF(2^8): shift left, reduce when the top bit falls out.
    function automatic logic [7:0] aes_rcon_next(input logic [7:0] rcon);
        logic [7:0] shifted;
        shifted = {rcon[6:0], 1'b0};
        return rcon[7] ? (shifted ^ AES_RCON_POLY) : shifted;
    endfunction

endpackage

// File: rtl/aes_key_shedualing.sv
// aes_key_shedualing
// One combinational AES-128 key-schedule round: RotWord/SubWord/rcon on the
// last column, then the running XOR chain across the four columns.
// Byte n of a key sits at [8n+7:8n]; column c at [32c+31:32c].
// Ports:
//   prev_key  in  128  round key r-1
//   rcon      in  8    round constant for round r
//   next_key  out 128  round key r

module aes_key_shedualing
    import aes_key_expand_ctrl_pkg::*;
(
    input  aes_rk_t    prev_key,
    input  logic [7:0] rcon,
    output aes_rk_t    next_key
);

    // S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry b lives at bit offset 8*(255-b) = {~b, 3'b000}.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;

    always_comb begin
        w0 = prev_key[31:0];
        w1 = prev_key[63:32];
        w2 = prev_key[95:64];
        w3 = prev_key[127:96];
        // Byte 0 of the rotated word is byte 1 of w3; rcon lands on byte 0.
        t  = {sbox(w3[7:0]), sbox(w3[31:24]), sbox(w3[23:16]), sbox(w3[15:8]) ^ rcon};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        next_key = {n3, n2, n1, n0};
    end

endmodule

// File: rtl/aes_key_expand_ctrl.sv
// aes_key_expand_ctrl
// Expands an AES-128 cipher key into 11 round keys, one round per clock,
// using a single key-schedule round instance and an 11x128 register file.
// Round keys are read back through a registered port at any time.
// Build option: define AES_KEY_EXP_DEC_ORDER_EN to read in decryption order
// (index i returns round key 10-i).
// Ports:
//   clk          in  1    rising-edge clock
//   nreset       in  1    synchronous active-low reset
//   key_v_i      in  1    cipher key valid
//   key_i        in  128  cipher key
//   key_ready_o  out 1    key can be accepted (IDLE or READY)
//   rk_valid_o   out 1    all 11 round keys stored
//   rk_idx_i     in  4    round-key read index (0..10)
//   rk_o         out 128  registered read data (0 for index > 10)
//   busy_o       out 1    expansion in progress

module aes_key_expand_ctrl
    import aes_key_expand_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         nreset,
    input  logic         key_v_i,
    input  logic [127:0] key_i,
    output logic         key_ready_o,
    output logic         rk_valid_o,
    input  logic [3:0]   rk_idx_i,
    output logic [127:0] rk_o,
    output logic         busy_o
);

    aes_kexp_state_e state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [7:0]      rcon_q, rcon_d;
    logic            rk_valid_q, rk_valid_d;
    aes_rk_t         rk_q, rk_d;

    // Round-key storage; deliberately not reset.
    aes_rk_t         slot_q [AES_RK_NUM];

    logic            slot_we;
    logic [3:0]      slot_waddr;
    aes_rk_t         slot_wdata;

    logic [3:0]      prev_idx;
    aes_rk_t         sched_in;
    aes_rk_t         sched_out;

    logic [3:0]      rd_addr;
    logic            rd_in_range;

    // Previous slot for the schedule round; cnt is 1..10 whenever it matters.
    assign prev_idx = (cnt_q == 4'd0) ? 4'd0 : (cnt_q - 4'd1);
    assign sched_in = slot_q[prev_idx];

    aes_key_shedualing u_sched (
        .prev_key (sched_in),
        .rcon     (rcon_q),
        .next_key (sched_out)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rcon_d     = rcon_q;
        rk_valid_d = rk_valid_q;
        slot_we    = 1'b0;
        slot_waddr = cnt_q;
        slot_wdata = sched_out;

        unique case (state_q)
            StIdle, StReady: begin
                if (key_v_i) begin
                    slot_we    = 1'b1;
                    slot_waddr = 4'd0;
                    slot_wdata = key_i;
                    cnt_d      = 4'd1;
                    rcon_d     = AES_RCON_INIT;
                    rk_valid_d = 1'b0;
                    state_d    = StExpand;
                end
            end
            StExpand: begin
                slot_we = 1'b1;
                cnt_d   = cnt_q + 4'd1;
                rcon_d  = aes_rcon_next(rcon_q);
                if (cnt_q == 4'(AES_NR)) begin
                    rk_valid_d = 1'b1;
                    state_d    = StReady;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            rcon_q     <= AES_RCON_INIT;
            rk_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rcon_q     <= rcon_d;
            rk_valid_q <= rk_valid_d;
        end
    end

    // Writes are suppressed while reset is asserted so an aborted round
    // cannot land in storage on the reset edge.
    always_ff @(posedge clk) begin
        if (nreset && slot_we) begin
            slot_q[slot_waddr] <= slot_wdata;
        end
    end

`ifdef AES_KEY_EXP_DEC_ORDER_EN
    assign rd_addr = 4'(AES_NR) - rk_idx_i;
`else
    assign rd_addr = rk_idx_i;
`endif
    assign rd_in_range = (rk_idx_i <= 4'(AES_NR));

    // Reads slot_q before this edge's write takes effect: same-edge reads
    // see the old contents.
    always_comb begin
        rk_d = '0;
        if (rd_in_range) begin
            rk_d = slot_q[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            rk_q <= '0;
        end else begin
            rk_q <= rk_d;
        end
    end

    assign key_ready_o = (state_q != StExpand);
    assign busy_o      = (state_q == StExpand);
    assign rk_valid_o  = rk_valid_q;
    assign rk_o        = rk_q;

endmodule

// File: tb/tb_aes_key_expand_ctrl.sv
// tb_aes_key_expand_ctrl
// Self-checking bench for aes_key_expand_ctrl. The reference model builds
// the S-box from GF(2^8) inverses plus the affine map and runs the FIPS-197
// word-oriented key expansion; random keys and stray key_v_i pulses are
// drawn with $urandom.

module tb_aes_key_expand_ctrl;

    typedef logic [127:0] key_t;

    localparam key_t FIPS_KEY = 128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b;
    localparam key_t FIPS_RK1 = 128'h05766c2a_3939a323_b12c5488_17fefaa0;
    localparam key_t FIPS_RK10 = 128'ha60c63b6_c80c3fe1_8925eec9_a8f914d0;

    logic         clk = 1'b0;
    logic         nreset;
    logic         key_v_i;
    logic [127:0] key_i;
    logic         key_ready_o;
    logic         rk_valid_o;
    logic [3:0]   rk_idx_i;
    logic [127:0] rk_o;
    logic         busy_o;

    int total = 0;
    int bad = 0;

    logic [7:0] sbox_ref [256];
    key_t       rk_exp [11];
    key_t       rk_old [11];

    always #5 clk = ~clk;

    aes_key_expand_ctrl dut (
        .clk         (clk),
        .nreset      (nreset),
        .key_v_i     (key_v_i),
        .key_i       (key_i),
        .key_ready_o (key_ready_o),
        .rk_valid_o  (rk_valid_o),
        .rk_idx_i    (rk_idx_i),
        .rk_o        (rk_o),
        .busy_o      (busy_o)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_ref[x] = s;
        end
    endtask

    // FIPS-197 expansion over 44 words.
    task automatic model_expand(input key_t key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  b [4];
        int          r;
        r = 1;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                for (int j = 0; j < 4; j++) b[j] = sbox_ref[t[8*((j+1)%4) +: 8]];
                b[0] = b[0] ^ 8'(r);
                t = {b[3], b[2], b[1], b[0]};
                r = r * 2;
                if (r > 255) r = r ^ 'h11b;
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k < 11; k++) rk_exp[k] = {w[4*k+3], w[4*k+2], w[4*k+1], w[4*k]};
    endtask

    // Read index -> storage slot.
    function automatic int map_idx(input int idx);
`ifdef AES_KEY_EXP_DEC_ORDER_EN
        return 10 - idx;
`else
        return idx;
`endif
    endfunction

    function automatic key_t rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load a key and wait for rk_valid_o; glitch>0 pulses key_v_i with a
    // random key so that it is sampled on that edge of the expansion.
    task automatic load_and_wait(input key_t key, input int glitch);
        int n;
        key_v_i = 1'b1;
        key_i   = key;
        tick();
        key_v_i = 1'b0;
        key_i   = rand_key();
        check_eq("accept_valid_low", rk_valid_o, 1'b0);
        check_eq("accept_busy", busy_o, 1'b1);
        check_eq("accept_ready_low", key_ready_o, 1'b0);
        n = 0;
        do begin
            if (glitch != 0 && n == glitch - 1) begin
                key_v_i = 1'b1;
                key_i   = rand_key();
            end else begin
                key_v_i = 1'b0;
            end
            tick();
            n++;
            if (!rk_valid_o) check_eq("expand_busy", busy_o, 1'b1);
        end while (!rk_valid_o && n < 20);
        key_v_i = 1'b0;
        check_eq("latency", 128'(n), 128'd10);
        check_eq("done_busy", busy_o, 1'b0);
        check_eq("done_ready", key_ready_o, 1'b1);
    endtask

    task automatic read_idx(input int idx, output key_t data);
        rk_idx_i = 4'(idx);
        tick();
        data = rk_o;
    endtask

    task automatic readback_all();
        key_t d;
        for (int k = 0; k < 11; k++) begin
            read_idx(k, d);
            check_eq($sformatf("rk_idx%0d", k), d, rk_exp[map_idx(k)]);
        end
    endtask

    initial begin
        key_t d;
        int   k;
        int   s;

        nreset   = 1'b0;
        key_v_i  = 1'b0;
        key_i    = '0;
        rk_idx_i = 4'd0;
        build_sbox();

        repeat (3) tick();
        check_eq("rst_valid", rk_valid_o, 1'b0);
        check_eq("rst_busy", busy_o, 1'b0);
        check_eq("rst_rk", rk_o, 128'h0);
        check_eq("rst_ready", key_ready_o, 1'b1);
        nreset = 1'b1;
        tick();
        check_eq("ready_after_rst", key_ready_o, 1'b1);

        // FIPS-197 vector.
        model_expand(FIPS_KEY);
        load_and_wait(FIPS_KEY, 0);
        read_idx(map_idx(1), d);
        check_eq("fips_rk1", d, FIPS_RK1);
        read_idx(map_idx(10), d);
        check_eq("fips_rk10", d, FIPS_RK10);
        read_idx(map_idx(0), d);
        check_eq("fips_rk0", d, FIPS_KEY);
        readback_all();

        // Out-of-range indices.
        for (int i = 11; i < 16; i++) begin
            read_idx(i, d);
            check_eq($sformatf("oor_idx%0d", i), d, 128'h0);
        end

        // Exactly one edge of read latency.
        read_idx(1, d);
        rk_idx_i = 4'd10;
        #3;
        check_eq("rd_hold", rk_o, rk_exp[map_idx(1)]);
        tick();
        check_eq("rd_follow", rk_o, rk_exp[map_idx(10)]);

        // Stray key_v_i during expansion at edge 5 is ignored.
        load_and_wait(FIPS_KEY, 5);
        readback_all();

        // Random keys with random stray pulses.
        for (int r = 0; r < 3; r++) begin
            key_t key;
            key = rand_key();
            model_expand(key);
            load_and_wait(key, int'($urandom_range(1, 9)));
            readback_all();
        end

        // Restart from READY while watching one slot: old value until the
        // edge that rewrites it has passed, then the new round key.
        for (int i = 0; i < 11; i++) rk_old[i] = rk_exp[i];
        begin
            key_t key;
            key = rand_key();
            model_expand(key);
            k = int'($urandom_range(0, 10));
            s = map_idx(k);
            read_idx(k, d);
            check_eq("restart_pre", d, rk_old[s]);
            key_v_i = 1'b1;
            key_i   = key;
            tick();
            key_v_i = 1'b0;
            check_eq("restart_drop", rk_valid_o, 1'b0);
            check_eq("restart_e0", rk_o, rk_old[s]);
            for (int e = 1; e <= 10; e++) begin
                tick();
                check_eq($sformatf("restart_e%0d_rk", e), rk_o, (e <= s) ? rk_old[s] : rk_exp[s]);
                check_eq($sformatf("restart_e%0d_valid", e), rk_valid_o, (e == 10) ? 1'b1 : 1'b0);
            end
            readback_all();
        end

        // Reset at edge 4 of an expansion aborts it.
        key_v_i = 1'b1;
        key_i   = rand_key();
        tick();
        key_v_i = 1'b0;
        repeat (3) tick();
        nreset = 1'b0;
        tick();
        check_eq("abort_valid", rk_valid_o, 1'b0);
        check_eq("abort_rk", rk_o, 128'h0);
        check_eq("abort_ready", key_ready_o, 1'b1);
        check_eq("abort_busy", busy_o, 1'b0);
        nreset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_eq("abort_stays_invalid", rk_valid_o, 1'b0);
        end
        model_expand(FIPS_KEY);
        load_and_wait(FIPS_KEY, 0);
        read_idx(map_idx(1), d);
        check_eq("post_abort_rk1", d, FIPS_RK1);
        read_idx(map_idx(10), d);
        check_eq("post_abort_rk10", d, FIPS_RK10);
        readback_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
